// File: rtl/attn_v_spikes_lif.sv
`default_nettype none
// ============================================================================
// Module      : attn_v_spikes_lif
// Description : Leaky integrate-and-fire stage for attn@v accumulator results.
//               Two channels are integrated in parallel over TIME_STEPS beats.
//               Each channel is thresholded against V_TH and hard-reset when it
//               fires. One packed spike word is emitted per channel pair.
//
// Ports       : s_clk            - clock, rising edge
//               s_rst            - asynchronous reset, active low
//               i_attn_v_data    - {ch1, ch0} signed accumulators
//               i_attn_v_valid   - one time step per asserted cycle
//               i_flush          - synchronous abort of partial group and row
//               o_spikes_out_ext - {ch1 spikes[T-1:0], ch0 spikes[T-1:0]}
//               o_spikes_valid   - one-cycle pulse qualifying the word
//               o_spikes_last    - marks every GROUPS_PER_ROW-th word
//
// Revision    : 1.0 - initial release
// ============================================================================
module attn_v_spikes_lif #(
    parameter int TIME_STEPS     = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int V_TH           = 4,
    parameter int DECAY_SHIFT    = 1,
    parameter int GROUPS_PER_ROW = 8
) (
    input  logic                      s_clk,
    input  logic                      s_rst,
    input  logic [2*DATA_WIDTH-1:0]   i_attn_v_data,
    input  logic                      i_attn_v_valid,
    input  logic                      i_flush,
    output logic [2*TIME_STEPS-1:0]   o_spikes_out_ext,
    output logic                      o_spikes_valid,
    output logic                      o_spikes_last
);

    // Counter widths, kept at least one bit for degenerate parameter values.
    localparam int C_TW = (TIME_STEPS     > 1) ? $clog2(TIME_STEPS)     : 1;
    localparam int C_GW = (GROUPS_PER_ROW > 1) ? $clog2(GROUPS_PER_ROW) : 1;

    localparam logic [C_TW-1:0]              C_T_LAST = C_TW'(TIME_STEPS - 1);
    localparam logic [C_GW-1:0]              C_G_LAST = C_GW'(GROUPS_PER_ROW - 1);
    localparam logic signed [DATA_WIDTH-1:0] C_V_TH   = DATA_WIDTH'(V_TH);

    // ------------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------------
    logic [C_TW-1:0]         r_t_cnt;
    logic [C_GW-1:0]         r_g_cnt;
    logic [2*TIME_STEPS-1:0] r_partial;
    logic [2*TIME_STEPS-1:0] w_partial_nxt;
    logic [1:0]              w_spike;
    logic                    w_accept;
    logic                    w_group_end;

    // Flush wins over valid: the same-cycle beat is dropped.
    assign w_accept    = i_attn_v_valid & ~i_flush;
    assign w_group_end = w_accept && (r_t_cnt == C_T_LAST);

    // ------------------------------------------------------------------------
    // Per-channel membrane update
    // ------------------------------------------------------------------------
    genvar c;
    generate
        for (c = 0; c < 2; c++) begin : g_ch
            logic signed [DATA_WIDTH-1:0] r_mem;
            logic signed [DATA_WIDTH-1:0] w_x;
            logic signed [DATA_WIDTH-1:0] w_h;
            logic signed [DATA_WIDTH:0]   w_diff;
            logic signed [DATA_WIDTH:0]   w_step;

            assign w_x    = i_attn_v_data[c*DATA_WIDTH +: DATA_WIDTH];
            // One extra bit so X - V cannot wrap.
            assign w_diff = {w_x[DATA_WIDTH-1], w_x} - {r_mem[DATA_WIDTH-1], r_mem};
            // Arithmetic shift floors toward minus infinity.
            assign w_step = w_diff >>> DECAY_SHIFT;
            // H lies between V and X, so the low DATA_WIDTH bits of the
            // step are enough and the sum cannot overflow.
            assign w_h    = r_mem + w_step[DATA_WIDTH-1:0];
            assign w_spike[c] = (w_h >= C_V_TH);

            always_ff @(posedge s_clk or negedge s_rst) begin
                if (!s_rst) begin
                    r_mem <= '0;
                end else if (i_flush) begin
                    r_mem <= '0;
                end else if (w_accept) begin
                    // Hard reset on fire; every group starts from rest.
                    if (w_group_end || w_spike[c]) begin
                        r_mem <= '0;
                    end else begin
                        r_mem <= w_h;
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Partial spike word including the current beat
    // ------------------------------------------------------------------------
    always_comb begin
        w_partial_nxt = r_partial;
        w_partial_nxt[int'(r_t_cnt)]              = w_spike[0];
        w_partial_nxt[TIME_STEPS + int'(r_t_cnt)] = w_spike[1];
    end

    // ------------------------------------------------------------------------
    // Counters and partial register
    // ------------------------------------------------------------------------
    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            r_t_cnt   <= '0;
            r_g_cnt   <= '0;
            r_partial <= '0;
        end else if (i_flush) begin
            r_t_cnt   <= '0;
            r_g_cnt   <= '0;
            r_partial <= '0;
        end else if (w_accept) begin
            if (w_group_end) begin
                r_t_cnt   <= '0;
                r_partial <= '0;
                if (r_g_cnt == C_G_LAST) begin
                    r_g_cnt <= '0;
                end else begin
                    r_g_cnt <= r_g_cnt + 1'b1;
                end
            end else begin
                r_t_cnt   <= r_t_cnt + 1'b1;
                r_partial <= w_partial_nxt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output registers; the word is held until the next group boundary and
    // is deliberately left untouched by flush.
    // ------------------------------------------------------------------------
    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            o_spikes_out_ext <= '0;
            o_spikes_valid   <= 1'b0;
            o_spikes_last    <= 1'b0;
        end else begin
            o_spikes_valid <= w_group_end;
            o_spikes_last  <= w_group_end && (r_g_cnt == C_G_LAST);
            if (w_group_end) begin
                o_spikes_out_ext <= w_partial_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_attn_v_spikes_lif.sv
`default_nettype none
// ============================================================================
// Module      : tb_attn_v_spikes_lif
// Description : Scoreboard bench for attn_v_spikes_lif. Stimulus tasks run a
//               behavioural LIF model and queue expected words; a monitor
//               compares every output pulse and the held word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_attn_v_spikes_lif;

    localparam int T  = 4;
    localparam int DW = 16;
    localparam int VTH = 4;
    localparam int SH = 1;
    localparam int G  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [2*DW-1:0]   data = '0;
    logic              valid = 1'b0;
    logic              flush = 1'b0;
    logic [2*T-1:0]    spk;
    logic              sv;
    logic              sl;

    attn_v_spikes_lif #(
        .TIME_STEPS    (T),
        .DATA_WIDTH    (DW),
        .V_TH          (VTH),
        .DECAY_SHIFT   (SH),
        .GROUPS_PER_ROW(G)
    ) dut (
        .s_clk           (clk),
        .s_rst           (rst_n),
        .i_attn_v_data   (data),
        .i_attn_v_valid  (valid),
        .i_flush         (flush),
        .o_spikes_out_ext(spk),
        .o_spikes_valid  (sv),
        .o_spikes_last   (sl)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*T-1:0] word;
        logic           last;
        int             at_cyc;
    } exp_t;
    exp_t q[$];

    // Reference model state
    int             mv[2];
    int             mt;
    int             mg;
    logic [2*T-1:0] mpart;
    logic [2*T-1:0] held = '0;
    bit             mon_on = 1'b1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        mv[0] = 0; mv[1] = 0; mt = 0; mg = 0; mpart = '0;
    endtask

    // One accepted beat; model updated and expected word queued at issue.
    task automatic beat(int x0, int x1);
        int x, h;
        bit sp;
        data  = {x1[DW-1:0], x0[DW-1:0]};
        valid = 1'b1;
        flush = 1'b0;
        for (int c = 0; c < 2; c++) begin
            x  = (c == 0) ? x0 : x1;
            h  = mv[c] + ((x - mv[c]) >>> SH);
            sp = (h >= VTH);
            mv[c] = sp ? 0 : h;
            mpart[c*T + mt] = sp;
        end
        if (mt == T - 1) begin
            q.push_back('{word: mpart, last: (mg == G - 1), at_cyc: cyc + 1});
            mpart = '0; mv[0] = 0; mv[1] = 0; mt = 0;
            mg = (mg + 1) % G;
        end else begin
            mt++;
        end
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic idle(int n);
        valid = 1'b0;
        flush = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        valid = 1'b1;
        data  = $urandom;
        model_clear();
        @(posedge clk); #1;
        flush = 1'b0;
        valid = 1'b0;
    endtask

    function automatic int rnd_small();
        return int'($urandom_range(0, 80)) - 40;
    endfunction

    function automatic int rnd_full();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Monitor: scoreboard pops on every valid; word held in between.
    always @(negedge clk) begin
        if (mon_on) begin
            if (sl && !sv) begin
                checks++; errors++;
                $display("FAIL last_without_valid: last=1 valid=0 (cycle %0d)", cyc);
            end
            if (sv) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid: word %0h with empty queue (cycle %0d)", spk, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("word", 64'(spk), 64'(e.word));
                    check("last", 64'(sl), 64'(e.last));
                    check("latency_cycle", 64'(cyc), 64'(e.at_cyc));
                    held = e.word;
                end
            end else begin
                check("held_word", 64'(spk), 64'(held));
            end
        end
    end

    initial begin
        model_clear();
        #1;
        check("reset_word", 64'(spk), 64'h0);
        check("reset_valid", 64'(sv), 64'h0);
        check("reset_last", 64'(sl), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Basic fire pattern: expect 8'hAF
        repeat (4) beat(10, 6);
        idle(2);

        // Negative inputs and floor rounding: expect 8'h04
        beat(-3, 0); beat(-3, 0); beat(20, 0); beat(0, 0);
        idle(2);

        // Gapped input, then all-7s group: expect 8'hAF then 8'hAA
        for (int i = 0; i < 4; i++) begin
            beat(10, 6);
            idle(int'($urandom_range(1, 3)));
        end
        repeat (4) beat(7, 7);
        idle(3);

        // Row count: 16 back-to-back groups
        do_flush();
        for (int i = 0; i < 16 * T; i++) beat(rnd_small(), rnd_small());
        idle(3);

        // Flush mid-group with valid high
        beat(10, 6); beat(10, 6);
        do_flush();
        repeat (4) beat(10, 6);
        for (int i = 0; i < 8 * T; i++) beat(rnd_small(), rnd_small());
        idle(3);

        // Asynchronous reset after three beats
        beat(10, 6); beat(10, 6); beat(10, 6);
        #1;
        rst_n = 1'b0;
        held  = '0;
        model_clear();
        #1;
        check("async_reset_word", 64'(spk), 64'h0);
        check("async_reset_valid", 64'(sv), 64'h0);
        check("async_reset_last", 64'(sl), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        repeat (4) beat(10, 6);
        idle(2);

        // Randomized traffic with gaps, flushes and full-range values
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3)       do_flush();
            else if (r < 20) idle(int'($urandom_range(1, 3)));
            else if (r < 30) beat(rnd_full(), rnd_full());
            else             beat(rnd_small(), rnd_small());
        end
        idle(5);

        check("queue_drained", 64'(q.size()), 64'h0);
        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
